// File: rtl/dpram_pkg.sv
// Shared constants for the clearable true-dual-port RAM.
//   RDW_* : same-port read-during-write mode selectors
//   fill_state_t : fill sequencer state encoding
package dpram_pkg;

    localparam int unsigned RDW_NO_CHANGE   = 0;
    localparam int unsigned RDW_READ_FIRST  = 1;
    localparam int unsigned RDW_WRITE_FIRST = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fill_state_t;

endpackage : dpram_pkg

// File: rtl/dpram_fill_seq.sv
// Fill sequencer: sweeps an AW-bit address counter over the whole RAM.
//   i_clk        : clock
//   i_rst        : synchronous active-high reset
//   i_clr        : request (or restart) a fill sweep
//   o_busy       : high while the sweep runs
//   o_fill_we_c  : fill write enable (combinational, suppressed in reset cycle)
//   o_fill_adr   : address being filled
module dpram_fill_seq
    import dpram_pkg::*;
#(
    parameter int unsigned AW         = 11,
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    output logic          o_busy,
    output logic          o_fill_we_c,
    output logic [AW-1:0] o_fill_adr
);

    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

    fill_state_t   r_state;
    fill_state_t   w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;

    // State and counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= CLR_ON_RST ? ST_CLEAR : ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: a request in either state (re)starts the sweep from zero
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (i_clr) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = AW'(r_cnt + AW'(1));
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_busy      = (r_state == ST_CLEAR);
    // Memory must stay untouched during a reset cycle, even mid-sweep
    assign o_fill_we_c = (r_state == ST_CLEAR) && !i_rst;
    assign o_fill_adr  = r_cnt;

endmodule : dpram_fill_seq

// File: rtl/dpram_clr_tdp.sv
// Single-clock true-dual-port RAM with hardware fill sweep.
//   CL            : clock
//   RESET         : synchronous active-high reset
//   CLR           : fill sweep request pulse
//   BUSY          : sweep in progress
//   ADRSA/INA/WRA : port A address / write data / write enable
//   OUTA          : port A registered read data
//   ADRSB/INB/WRB : port B address / write data / write enable
//   OUTB          : port B registered read data
module dpram_clr_tdp
    import dpram_pkg::*;
#(
    parameter int unsigned    AW         = 11,
    parameter int unsigned    DW         = 8,
    parameter int unsigned    RDW_MODE   = RDW_NO_CHANGE,
    parameter bit             B_WRITE    = 1'b1,
    parameter bit             CLR_ON_RST = 1'b1,
    parameter logic [DW-1:0]  FILL       = '0
) (
    input  logic          CL,
    input  logic          RESET,
    input  logic          CLR,
    output logic          BUSY,
    input  logic [AW-1:0] ADRSA,
    input  logic [DW-1:0] INA,
    input  logic          WRA,
    output logic [DW-1:0] OUTA,
    input  logic [AW-1:0] ADRSB,
    input  logic [DW-1:0] INB,
    input  logic          WRB,
    output logic [DW-1:0] OUTB
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_outa;
    logic [DW-1:0] r_outb;

    logic          w_busy;
    logic          w_fill_we;
    logic [AW-1:0] w_fill_adr;
    logic          w_wr_req_b;
    logic          w_user_wa;
    logic          w_user_wb;
    logic          w_we_a;
    logic          w_we_b;
    logic [AW-1:0] w_adr_a;
    logic [DW-1:0] w_din_a;

    dpram_fill_seq #(
        .AW         (AW),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_fill_seq (
        .i_clk       (CL),
        .i_rst       (RESET),
        .i_clr       (CLR),
        .o_busy      (w_busy),
        .o_fill_we_c (w_fill_we),
        .o_fill_adr  (w_fill_adr)
    );

    // A read-only port B ignores WRB entirely, including for its RDW rule
    assign w_wr_req_b = B_WRITE && WRB;

    // User writes are dropped while sweeping and during a reset cycle
    assign w_user_wa = WRA && !w_busy && !RESET;
    assign w_user_wb = w_wr_req_b && !w_busy && !RESET;

    // The sweep owns port A's write path; B loses a same-address dual write
    assign w_we_a  = w_fill_we || w_user_wa;
    assign w_adr_a = w_fill_we ? w_fill_adr : ADRSA;
    assign w_din_a = w_fill_we ? FILL : INA;
    assign w_we_b  = w_user_wb && !(w_user_wa && (ADRSA == ADRSB));

    // Memory array, both write ports in one block
    always_ff @(posedge CL) begin
        if (w_we_a) begin
            r_mem[w_adr_a] <= w_din_a;
        end
        if (w_we_b) begin
            r_mem[ADRSB] <= INB;
        end
    end

    // Registered read ports; reads see the pre-write word, so cross-port
    // collisions always return old data
    always_ff @(posedge CL) begin
        if (RESET) begin
            r_outa <= '0;
            r_outb <= '0;
        end else if (!w_busy) begin
            if (!WRA || RDW_MODE == RDW_READ_FIRST) begin
                r_outa <= r_mem[ADRSA];
            end else if (RDW_MODE == RDW_WRITE_FIRST) begin
                r_outa <= INA;
            end
            if (!w_wr_req_b || RDW_MODE == RDW_READ_FIRST) begin
                r_outb <= r_mem[ADRSB];
            end else if (RDW_MODE == RDW_WRITE_FIRST) begin
                r_outb <= INB;
            end
        end
    end

    assign OUTA = r_outa;
    assign OUTB = r_outb;
    assign BUSY = w_busy;

endmodule : dpram_clr_tdp

// File: tb/tb_dpram_clr_tdp.sv
// Bench for dpram_clr_tdp: five variants share one stimulus stream and are
// compared every cycle against a word-level model, plus literal spot checks.
module tb_dpram_clr_tdp;

    localparam int NI    = 5;
    localparam int DEPTH = 16;
    localparam logic [7:0] FILLV = 8'hA5;

    // Variant table: u0 NO_CHANGE, u1 READ_FIRST, u2 WRITE_FIRST,
    // u3 WRITE_FIRST read-only B, u4 READ_FIRST without clear-on-reset
    function automatic int mode_of(input int g);
        return (g == 0) ? 0 : ((g == 1 || g == 4) ? 1 : 2);
    endfunction
    function automatic bit bw_of(input int g);
        return (g == 3) ? 1'b0 : 1'b1;
    endfunction
    function automatic bit cor_of(input int g);
        return (g == 4) ? 1'b0 : 1'b1;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clr, wra, wrb;
    logic [3:0] adra, adrb;
    logic [7:0] ina, inb;

    logic [NI-1:0]       busy_v;
    logic [NI-1:0][7:0]  outa_v;
    logic [NI-1:0][7:0]  outb_v;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dpram_clr_tdp #(
            .AW         (4),
            .DW         (8),
            .RDW_MODE   (mode_of(g)),
            .B_WRITE    (bw_of(g)),
            .CLR_ON_RST (cor_of(g)),
            .FILL       (8'hA5)
        ) u_dut (
            .CL    (clk),
            .RESET (rst),
            .CLR   (clr),
            .BUSY  (busy_v[g]),
            .ADRSA (adra),
            .INA   (ina),
            .WRA   (wra),
            .OUTA  (outa_v[g]),
            .ADRSB (adrb),
            .INB   (inb),
            .WRB   (wrb),
            .OUTB  (outb_v[g])
        );
    end

    int total = 0;
    int bad   = 0;

    // Behavioural model: word array, known flags, remaining sweep cycles
    logic [7:0] m_mem   [NI][DEPTH];
    bit         m_known [NI][DEPTH];
    logic [7:0] m_outa  [NI];
    logic [7:0] m_outb  [NI];
    bit         m_ka    [NI];
    bit         m_kb    [NI];
    int         m_left  [NI];
    bit         started = 1'b0;

    task automatic model_step(input int k);
        logic [7:0] olda, oldb;
        bit         ka, kb, wb;
        int         idx;
        olda = m_mem[k][adra];
        ka   = m_known[k][adra];
        oldb = m_mem[k][adrb];
        kb   = m_known[k][adrb];
        if (rst) begin
            m_outa[k] = 8'h00; m_ka[k] = 1'b1;
            m_outb[k] = 8'h00; m_kb[k] = 1'b1;
            m_left[k] = cor_of(k) ? DEPTH : 0;
        end else if (m_left[k] > 0) begin
            idx = DEPTH - m_left[k];
            m_mem[k][idx]   = FILLV;
            m_known[k][idx] = 1'b1;
            m_left[k] = clr ? DEPTH : m_left[k] - 1;
        end else begin
            wb = bw_of(k) && wrb;
            if (!wra || mode_of(k) == 1) begin
                m_outa[k] = olda; m_ka[k] = ka;
            end else if (mode_of(k) == 2) begin
                m_outa[k] = ina; m_ka[k] = 1'b1;
            end
            if (!wb || mode_of(k) == 1) begin
                m_outb[k] = oldb; m_kb[k] = kb;
            end else if (mode_of(k) == 2) begin
                m_outb[k] = inb; m_kb[k] = 1'b1;
            end
            if (wb && !(wra && adra == adrb)) begin
                m_mem[k][adrb] = inb; m_known[k][adrb] = 1'b1;
            end
            if (wra) begin
                m_mem[k][adra] = ina; m_known[k][adra] = 1'b1;
            end
            if (clr) m_left[k] = DEPTH;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) model_step(k);
        if (rst) started = 1'b1;
    end

    // Cycle-by-cycle comparison of every variant against the model
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < NI; k++) begin
                total++;
                if (busy_v[k] !== 1'(m_left[k] > 0)) begin
                    bad++;
                    $display("FAIL u%0d busy got=%b exp=%b t=%0t", k, busy_v[k], m_left[k] > 0, $time);
                end
                if (m_ka[k]) begin
                    total++;
                    if (outa_v[k] !== m_outa[k]) begin
                        bad++;
                        $display("FAIL u%0d outa got=%h exp=%h t=%0t", k, outa_v[k], m_outa[k], $time);
                    end
                end
                if (m_kb[k]) begin
                    total++;
                    if (outb_v[k] !== m_outb[k]) begin
                        bad++;
                        $display("FAIL u%0d outb got=%h exp=%h t=%0t", k, outb_v[k], m_outb[k], $time);
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Counts consecutive sampled cycles with u0 BUSY high, bounded
    task automatic count_busy(output int n);
        n = 0;
        while (busy_v[0] && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        rst = 1'b1; clr = 1'b0; wra = 1'b0; wrb = 1'b0;
        adra = '0; adrb = '0; ina = '0; inb = '0;

        // Reset state and sweep length
        @(negedge clk);
        check("rst_outa", outa_v[0], 8'h00);
        check("rst_outb", outb_v[0], 8'h00);
        check("rst_busy", {7'd0, busy_v[0]}, 8'h01);
        check("rst_busy_nocor", {7'd0, busy_v[4]}, 8'h00);
        rst = 1'b0;
        count_busy(n);
        check("sweep_len", 8'(n), 8'd16);

        // Fill u4 too, then read back every word on both ports
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        count_busy(n);
        for (int a = 0; a < DEPTH; a++) begin
            adra = 4'(a); adrb = 4'(DEPTH - 1 - a);
            @(negedge clk);
            check("fill_a_u0", outa_v[0], FILLV);
            check("fill_b_u4", outb_v[4], FILLV);
        end

        // Write then cross-port read
        wra = 1'b1; adra = 4'd3; ina = 8'h3C; @(negedge clk);
        wra = 1'b0; adrb = 4'd3; @(negedge clk);
        check("xread_b", outb_v[0], 8'h3C);

        // Write attempted during sweep is dropped
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        wra = 1'b1; adra = 4'd4; ina = 8'h77; @(negedge clk); wra = 1'b0;
        count_busy(n);
        adra = 4'd4; @(negedge clk);
        check("busy_wr_drop", outa_v[0], FILLV);

        // Same-port RDW modes with a concurrent cross-port read
        wra = 1'b1; adra = 4'd5; ina = 8'h11; @(negedge clk);
        wra = 1'b0; adra = 4'd2; @(negedge clk);
        wra = 1'b1; adra = 4'd5; ina = 8'h22; adrb = 4'd5; @(negedge clk);
        wra = 1'b0;
        check("rdw_nochange", outa_v[0], FILLV);
        check("rdw_readfirst", outa_v[1], 8'h11);
        check("rdw_writefirst", outa_v[2], 8'h22);
        check("coll_b_old_u0", outb_v[0], 8'h11);
        check("coll_b_old_u2", outb_v[2], 8'h11);
        @(negedge clk);
        check("rdw_written", outa_v[0], 8'h22);

        // Dual write to one address: A wins
        wra = 1'b1; wrb = 1'b1; adra = 4'd7; adrb = 4'd7; ina = 8'h01; inb = 8'h02;
        @(negedge clk);
        wra = 1'b0; wrb = 1'b0;
        check("dual_b_wf", outb_v[2], 8'h02);
        adrb = 4'd0; @(negedge clk);
        check("dual_a_wins", outa_v[0], 8'h01);

        // Read-only port B ignores WRB
        wrb = 1'b1; adrb = 4'd7; inb = 8'h55; @(negedge clk);
        wrb = 1'b0; @(negedge clk);
        check("bro_kept_a", outa_v[3], 8'h01);
        check("bro_kept_b", outb_v[3], 8'h01);
        check("bw_written", outa_v[0], 8'h55);

        // No clear-on-reset: contents retained, no sweep
        wra = 1'b1; adra = 4'd9; ina = 8'h5A; @(negedge clk);
        wra = 1'b0; rst = 1'b1; @(negedge clk);
        rst = 1'b0;
        check("nocor_busy", {7'd0, busy_v[4]}, 8'h00);
        check("nocor_outa", outa_v[4], 8'h00);
        check("cor_busy", {7'd0, busy_v[0]}, 8'h01);
        @(negedge clk);
        check("nocor_retain", outa_v[4], 8'h5A);
        count_busy(n);

        // CLR at sweep count 9 restarts a full sweep
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        repeat (9) @(negedge clk);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        count_busy(n);
        check("clr_restart_len", 8'(n), 8'd16);

        // RESET at sweep count 9 zeroes outputs and restarts
        adra = 4'd7; adrb = 4'd7; @(negedge clk);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("midrst_outa", outa_v[0], 8'h00);
        check("midrst_outb", outb_v[0], 8'h00);
        count_busy(n);
        check("midrst_len", 8'(n), 8'd16);

        // Randomized traffic with frequent collisions
        for (int i = 0; i < 1500; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            clr  = ($urandom_range(0, 79) == 0);
            wra  = 1'($urandom_range(0, 1));
            wrb  = 1'($urandom_range(0, 1));
            adra = 4'($urandom);
            adrb = ($urandom_range(0, 3) == 0) ? adra : 4'($urandom);
            ina  = 8'($urandom);
            inb  = 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; clr = 1'b0; wra = 1'b0; wrb = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dpram_clr_tdp
